// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer port arbiter.
//   H_RES/V_RES : framebuffer size in pixels (320x240)
//   ADDR_W      : BRAM address width
//   DATA_W      : pixel width (RGB444)
//   pixel_t     : one framebuffer pixel
//   slot_e      : what the BRAM port does on the next cycle
//   fb_addr()   : row-major address y*320 + x built from shifts and adds
package fb_pkg;

   localparam int unsigned H_RES  = 320;
   localparam int unsigned V_RES  = 240;
   localparam int unsigned ADDR_W = 17;
   localparam int unsigned DATA_W = 12;

   typedef logic [DATA_W-1:0] pixel_t;

   typedef enum logic [1:0] {
      SLOT_IDLE,
      SLOT_READ,
      SLOT_WRITE,
      SLOT_DROP
   } slot_e;

   // y*320 = y*256 + y*64; the largest address (76799) fits in ADDR_W bits.
   function automatic logic [ADDR_W-1:0] fb_addr(input logic [8:0] x, input logic [8:0] y);
      logic [ADDR_W-1:0] xe;
      logic [ADDR_W-1:0] ye;
      xe = ADDR_W'(x);
      ye = ADDR_W'(y);
      return (ye << 8) + (ye << 6) + xe;
   endfunction

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Writer-side valid/ready handshake of the framebuffer port arbiter.
//   wr_valid : writer request
//   wr_ready : write slot available (driven by the arbiter)
//   wr_x     : write column
//   wr_y     : write row
//   wr_data  : write pixel
// Modports: master = game/sprite writer, slave = arbiter.
interface fb_port_arbiter_if;
   import fb_pkg::*;

   logic       wr_valid;
   logic       wr_ready;
   logic [8:0] wr_x;
   logic [7:0] wr_y;
   pixel_t     wr_data;

   modport master (
      output wr_valid,
      output wr_x,
      output wr_y,
      output wr_data,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_x,
      input  wr_y,
      input  wr_data,
      output wr_ready
   );

endinterface

// File: rtl/fb_rd_pipe.sv
// Display read pipeline: delays the read-issued flag by the BRAM read
// latency and captures mem_rdata into pix_data, holding each fetched pixel
// for the two clock cycles a 320-wide pixel occupies on screen.
//   clk, rst   : clock, synchronous active-high reset (flushes the pipe)
//   rd_issue   : a display read is on the BRAM port this cycle
//   mem_rdata  : BRAM read data, RD_LAT cycles after rd_issue
//   pix_data   : pixel to the display stage, 0 when nothing was fetched
//   pix_valid  : pix_data holds a fetched framebuffer pixel
module fb_rd_pipe
   import fb_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   rd_issue,
   input  pixel_t mem_rdata,
   output pixel_t pix_data,
   output logic   pix_valid
);

   logic [RD_LAT-1:0] issue_sr;
   logic              data_here;
   logic              hold;

   generate
      if (RD_LAT == 1) begin : g_lat1
         always_ff @(posedge clk) begin
            if (rst) issue_sr <= '0;
            else     issue_sr <= rd_issue;
         end
      end else begin : g_latn
         always_ff @(posedge clk) begin
            if (rst) issue_sr <= '0;
            else     issue_sr <= {issue_sr[RD_LAT-2:0], rd_issue};
         end
      end
   endgenerate

   // High in the cycle the BRAM presents data for an issued read.
   assign data_here = issue_sr[RD_LAT-1];

   // Capture, then hold exactly one extra cycle, then clear to black.
   always_ff @(posedge clk) begin
      if (rst) begin
         pix_data  <= '0;
         pix_valid <= 1'b0;
         hold      <= 1'b0;
      end else if (data_here) begin
         pix_data  <= mem_rdata;
         pix_valid <= 1'b1;
         hold      <= 1'b1;
      end else if (hold) begin
         hold      <= 1'b0;
      end else begin
         pix_data  <= '0;
         pix_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fb_port_arbiter.sv
// Time-multiplexes the single-port 320x240x12 framebuffer BRAM between the
// VGA display read path (absolute priority, even h_cnt phases of active
// video) and a game/sprite writer using a valid/ready handshake.
// Build option: FB_BLANK_WRITE_EN - when defined, writes are granted on every
// cycle that is not a display read (full bandwidth in blanking); otherwise
// writes are granted only on odd h_cnt phases.
//   clk, rst     : 25 MHz pixel clock, synchronous active-high reset
//   h_cnt, v_cnt : VGA timing counters
//   visible      : VGA active-video flag
//   wr           : writer handshake (wr_valid/wr_ready/wr_x/wr_y/wr_data)
//   mem_*        : registered BRAM port, mem_rdata returns RD_LAT later
//   pix_data     : image_data to the pixel-to-RGB stage (RD_LAT+2 latency)
//   pix_valid    : pix_data holds a fetched framebuffer pixel
//   wr_drop_cnt  : saturating count of out-of-range writes
module fb_port_arbiter
   import fb_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [9:0]          h_cnt,
   input  logic [9:0]          v_cnt,
   input  logic                visible,
   fb_port_arbiter_if.slave    wr,
   output logic                mem_en,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output pixel_t              mem_wdata,
   input  pixel_t              mem_rdata,
   output pixel_t              pix_data,
   output logic                pix_valid,
   output logic [7:0]          wr_drop_cnt
);

   logic [8:0] x;
   logic [8:0] y;
   logic       active;
   logic       read_slot;
   logic       write_slot;
   logic       wr_ready_int;
   logic       in_range;
   slot_e      slot;

   assign x      = h_cnt[9:1];
   assign y      = v_cnt[9:1];
   assign active = visible && (x < 9'(H_RES)) && (y < 9'(V_RES));

   assign read_slot = active && !h_cnt[0];
`ifdef FB_BLANK_WRITE_EN
   assign write_slot = !read_slot;
`else
   assign write_slot = !read_slot && h_cnt[0];
`endif

   assign wr_ready_int = write_slot && !rst;
   assign wr.wr_ready  = wr_ready_int;

   assign in_range = (wr.wr_x < 9'(H_RES)) && (wr.wr_y < 8'(V_RES));

   // Reads outrank writes; write_slot already excludes read slots, the
   // ordering here just makes the priority explicit.
   always_comb begin
      slot = SLOT_IDLE;
      if (read_slot)
         slot = SLOT_READ;
      else if (wr.wr_valid && wr_ready_int)
         slot = in_range ? SLOT_WRITE : SLOT_DROP;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         wr_drop_cnt <= '0;
      end else begin
         mem_en <= 1'b0;
         mem_we <= 1'b0;
         case (slot)
            SLOT_READ: begin
               mem_en   <= 1'b1;
               mem_addr <= fb_addr(x, y);
            end
            SLOT_WRITE: begin
               mem_en    <= 1'b1;
               mem_we    <= 1'b1;
               mem_addr  <= fb_addr(wr.wr_x, {1'b0, wr.wr_y});
               mem_wdata <= wr.wr_data;
            end
            SLOT_DROP: begin
               if (wr_drop_cnt != 8'hFF)
                  wr_drop_cnt <= wr_drop_cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

   fb_rd_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .rd_issue  (mem_en && !mem_we),
      .mem_rdata (mem_rdata),
      .pix_data  (pix_data),
      .pix_valid (pix_valid)
   );

endmodule
